// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared definitions for the register-file writeback arbiter slice.
//   REG_ADDR_W / REG_DATA_W : register address and data widths
//   REG_ZERO                : address of the hard-wired zero register
//   WAIT_MAX                : saturation value of the starvation counters
//   rr_state_t              : round-robin memory of the last granted requester
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [3:0] WAIT_MAX = 4'd15;

  typedef enum logic {
    LAST_A,
    LAST_B
  } rr_state_t;

endpackage

// File: rtl/wb_wait_counter.sv
// wb_wait_counter
// Saturating 4-bit starvation counter. It counts cycles in which its requester
// waits, holds at WAIT_MAX, and returns to zero when the requester is granted.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset (count returns to 0)
//   inc    requester valid but not granted this cycle
//   clr    requester granted this cycle (takes priority over inc)
//   count  current wait count
module wb_wait_counter
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] count
);

  // Clear wins over increment; the count never wraps past WAIT_MAX.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != WAIT_MAX)) begin
      count <= count + 4'd1;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Arbitrates two writeback requesters (A: ALU, B: load) onto the single
// register-file write port, with one cycle of registered latency.
// Optional macro RF_WB_FWD_EN enables forwarding from the output stage.
// Ports:
//   clk, reset                      clock and synchronous active-high reset
//   a_valid/a_ready/a_addr/a_data   requester A handshake and payload
//   b_valid/b_ready/b_addr/b_data   requester B handshake and payload
//   wb_stall                        blocks all new grants while high
//   rf_write/rf_waddr/rf_wdata      registered register-file write port
//   fwd_rs/fwd_rt                   source registers to compare for forwarding
//   fwd_hit_rs/fwd_hit_rt/fwd_data  forwarding result from the output stage
module regfile_wb_arbiter
  import regfile_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [REG_ADDR_W-1:0] a_addr,
  input  logic [REG_DATA_W-1:0] a_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [REG_ADDR_W-1:0] b_addr,
  input  logic [REG_DATA_W-1:0] b_data,
  input  logic                  wb_stall,
  output logic                  rf_write,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [REG_DATA_W-1:0] rf_wdata,
  input  logic [REG_ADDR_W-1:0] fwd_rs,
  input  logic [REG_ADDR_W-1:0] fwd_rt,
  output logic                  fwd_hit_rs,
  output logic                  fwd_hit_rt,
  output logic [REG_DATA_W-1:0] fwd_data
);

  rr_state_t             rr_state;
  rr_state_t             rr_next;
  logic                  grant_a;
  logic                  grant_b;
  logic [3:0]            a_wait_cnt;
  logic [3:0]            b_wait_cnt;
  logic                  a_starved;
  logic                  b_starved;
  logic [REG_ADDR_W-1:0] sel_addr;
  logic [REG_DATA_W-1:0] sel_data;

  assign a_starved = (a_wait_cnt == WAIT_MAX);
  assign b_starved = (b_wait_cnt == WAIT_MAX);

  wb_wait_counter u_a_wait (
    .clk   (clk),
    .reset (reset),
    .inc   (a_valid && !grant_a),
    .clr   (grant_a),
    .count (a_wait_cnt)
  );

  wb_wait_counter u_b_wait (
    .clk   (clk),
    .reset (reset),
    .inc   (b_valid && !grant_b),
    .clr   (grant_b),
    .count (b_wait_cnt)
  );

  // The round-robin memory starts as LAST_B so A is favoured first.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_state <= LAST_B;
    end else begin
      rr_state <= rr_next;
    end
  end

  // Grant selection. A grant implies its valid, so a grant is a transfer.
  // A starved requester overrides round-robin; A wins if both are starved.
  // The round-robin memory only moves when something is actually granted,
  // which keeps it intact across stalls and idle cycles.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    rr_next = rr_state;
    if (!reset && !wb_stall) begin
      if (a_valid && b_valid) begin
        if (a_starved) begin
          grant_a = 1'b1;
        end else if (b_starved) begin
          grant_b = 1'b1;
        end else if (rr_state == LAST_B) begin
          grant_a = 1'b1;
        end else begin
          grant_b = 1'b1;
        end
      end else if (a_valid) begin
        grant_a = 1'b1;
      end else if (b_valid) begin
        grant_b = 1'b1;
      end
    end
    if (grant_a) begin
      rr_next = LAST_A;
    end else if (grant_b) begin
      rr_next = LAST_B;
    end
  end

  assign a_ready  = grant_a;
  assign b_ready  = grant_b;
  assign sel_addr = grant_b ? b_addr : a_addr;
  assign sel_data = grant_b ? b_data : a_data;

  // Output stage. Writes to the zero register are accepted and still move
  // the address/data registers, but never raise the write enable. A
  // pending write is dropped by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_write <= 1'b0;
      rf_waddr <= REG_ZERO;
      rf_wdata <= '0;
    end else if (grant_a || grant_b) begin
      rf_write <= (sel_addr != REG_ZERO);
      rf_waddr <= sel_addr;
      rf_wdata <= sel_data;
    end else begin
      rf_write <= 1'b0;
    end
  end

`ifdef RF_WB_FWD_EN
  // rf_write is never set for address 0, but the explicit zero check keeps
  // the forwarding path independent of that guarantee.
  assign fwd_hit_rs = rf_write && (rf_waddr == fwd_rs) && (fwd_rs != REG_ZERO);
  assign fwd_hit_rt = rf_write && (rf_waddr == fwd_rt) && (fwd_rt != REG_ZERO);
  assign fwd_data   = rf_wdata;
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd_rs, fwd_rt};
  assign fwd_hit_rs = 1'b0;
  assign fwd_hit_rt = 1'b0;
  assign fwd_data   = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter
// Directed scenarios followed by randomized traffic. The stimulus side
// predicts handshakes and queues expected register-file writes; a separate
// monitor pops and compares them against the output stage every cycle.
// Honors RF_WB_FWD_EN the same way the design does.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid, b_valid, wb_stall;
  logic [4:0]  a_addr, b_addr, fwd_rs, fwd_rt;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready, rf_write, fwd_hit_rs, fwd_hit_rt;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, fwd_data;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  typedef struct {
    int          due;
    bit          wr;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t expq[$];

  // Reference model state: who was granted last and how long each side waited.
  bit last_was_a = 1'b0;
  int wait_a = 0;
  int wait_b = 0;

  // Monitor's view of what the output registers should currently hold.
  logic [4:0]  held_addr = 5'd0;
  logic [31:0] held_data = 32'd0;

  regfile_wb_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .a_valid    (a_valid),
    .a_ready    (a_ready),
    .a_addr     (a_addr),
    .a_data     (a_data),
    .b_valid    (b_valid),
    .b_ready    (b_ready),
    .b_addr     (b_addr),
    .b_data     (b_data),
    .wb_stall   (wb_stall),
    .rf_write   (rf_write),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .fwd_rs     (fwd_rs),
    .fwd_rt     (fwd_rt),
    .fwd_hit_rs (fwd_hit_rs),
    .fwd_hit_rt (fwd_hit_rt),
    .fwd_data   (fwd_data)
  );

  always #5 clk = ~clk;

  // Cycle index, advanced at every rising edge.
  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h cycle=%0d", name, act, expv, cycle);
    end
  endtask

  // Drives one cycle of inputs, checks the handshake against the model at the
  // falling edge, advances the model and queues the write due next cycle.
  task automatic applyStimulus(input bit rst, input bit stall,
                               input bit av, input logic [4:0] aa, input logic [31:0] ad,
                               input bit bv, input logic [4:0] ba, input logic [31:0] bd,
                               input logic [4:0] rs, input logic [4:0] rt);
    bit   ga, gb;
    exp_t e;
    reset    = rst;
    wb_stall = stall;
    a_valid  = av;
    a_addr   = aa;
    a_data   = ad;
    b_valid  = bv;
    b_addr   = ba;
    b_data   = bd;
    fwd_rs   = rs;
    fwd_rt   = rt;
    @(negedge clk);
    ga = 1'b0;
    gb = 1'b0;
    if (!rst && !stall) begin
      if (av && bv) begin
        if (wait_a == 15)      ga = 1'b1;
        else if (wait_b == 15) gb = 1'b1;
        else if (last_was_a)   gb = 1'b1;
        else                   ga = 1'b1;
      end else if (av) begin
        ga = 1'b1;
      end else if (bv) begin
        gb = 1'b1;
      end
    end
    checkOutput("a_ready", {31'd0, a_ready}, {31'd0, ga});
    checkOutput("b_ready", {31'd0, b_ready}, {31'd0, gb});
    if (rst) begin
      last_was_a = 1'b0;
      wait_a = 0;
      wait_b = 0;
      e.due  = cycle + 1;
      e.wr   = 1'b0;
      e.addr = 5'd0;
      e.data = 32'd0;
      expq.push_back(e);
    end else begin
      if (ga) wait_a = 0;
      else if (av && wait_a < 15) wait_a++;
      if (gb) wait_b = 0;
      else if (bv && wait_b < 15) wait_b++;
      if (ga) last_was_a = 1'b1;
      if (gb) last_was_a = 1'b0;
      if (ga || gb) begin
        e.due  = cycle + 1;
        e.addr = ga ? aa : ba;
        e.data = ga ? ad : bd;
        e.wr   = (e.addr != 5'd0);
        expq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [4:0] rs, input logic [4:0] rt);
    applyStimulus(0, 0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, rs, rt);
  endtask

  // Monitor: one expected output-stage state per cycle.
  initial begin
    exp_t        e;
    bit          ew;
    logic        hit_rs, hit_rt;
    logic [31:0] fdata;
    forever begin
      @(negedge clk);
      ew = 1'b0;
      if (expq.size() > 0 && expq[0].due == cycle) begin
        e = expq.pop_front();
        ew = e.wr;
        held_addr = e.addr;
        held_data = e.data;
      end
      checkOutput("rf_write", {31'd0, rf_write}, {31'd0, ew});
      checkOutput("rf_waddr", {27'd0, rf_waddr}, {27'd0, held_addr});
      checkOutput("rf_wdata", rf_wdata, held_data);
`ifdef RF_WB_FWD_EN
      hit_rs = ew && (held_addr == fwd_rs);
      hit_rt = ew && (held_addr == fwd_rt);
      fdata  = held_data;
`else
      hit_rs = 1'b0;
      hit_rt = 1'b0;
      fdata  = 32'd0;
`endif
      checkOutput("fwd_hit_rs", {31'd0, fwd_hit_rs}, {31'd0, hit_rs});
      checkOutput("fwd_hit_rt", {31'd0, fwd_hit_rt}, {31'd0, hit_rt});
      checkOutput("fwd_data", fwd_data, fdata);
    end
  end

  initial begin
    bit         r, s, av, bv;
    logic [4:0] aa, ba;

    // Reset
    repeat (2) applyStimulus(1, 0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd0, 5'd0);

    // Single request from A
    applyStimulus(0, 0, 1, 5'd3, 32'h0000_00AA, 0, 5'd0, 32'd0, 5'd0, 5'd0);
    idle(5'd3, 5'd0);
    idle(5'd0, 5'd0);

    // Contention from reset: A,B,A,B
    applyStimulus(1, 0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd0, 5'd0);
    for (int i = 0; i < 4; i++)
      applyStimulus(0, 0, 1, 5'd1, $urandom, 1, 5'd2, $urandom, 5'd1, 5'd2);
    idle(5'd2, 5'd1);

    // Zero register write is accepted but not written
    applyStimulus(0, 0, 0, 5'd0, 32'd0, 1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
    idle(5'd0, 5'd0);

    // Stall after a grant to A; B goes first afterwards
    applyStimulus(1, 0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd0, 5'd0);
    applyStimulus(0, 0, 1, 5'd4, 32'h0000_0044, 1, 5'd6, 32'h0000_0066, 5'd4, 5'd6);
    repeat (3) applyStimulus(0, 1, 1, 5'd4, 32'h0000_0045, 1, 5'd6, 32'h0000_0067, 5'd4, 5'd6);
    applyStimulus(0, 0, 1, 5'd4, 32'h0000_0046, 1, 5'd6, 32'h0000_0068, 5'd4, 5'd6);
    idle(5'd6, 5'd4);

    // Long stall saturates both counters; A is forced even though B is next
    applyStimulus(1, 0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd0, 5'd0);
    applyStimulus(0, 0, 1, 5'd9, 32'h0000_0099, 1, 5'd10, 32'h0000_00A0, 5'd0, 5'd0);
    repeat (16) applyStimulus(0, 1, 1, 5'd9, 32'h0000_0091, 1, 5'd10, 32'h0000_00A1, 5'd0, 5'd0);
    repeat (3) applyStimulus(0, 0, 1, 5'd9, 32'h0000_0092, 1, 5'd10, 32'h0000_00A2, 5'd9, 5'd10);
    idle(5'd0, 5'd0);

    // Reset mid-stream discards the pending write
    applyStimulus(0, 0, 1, 5'd5, 32'h0000_0055, 0, 5'd0, 32'd0, 5'd5, 5'd0);
    applyStimulus(1, 0, 1, 5'd5, 32'h0000_0056, 0, 5'd0, 32'd0, 5'd5, 5'd0);
    idle(5'd5, 5'd0);

    // Forwarding from the output stage
    applyStimulus(0, 0, 1, 5'd7, 32'h0000_1234, 0, 5'd0, 32'd0, 5'd0, 5'd0);
    idle(5'd7, 5'd8);
    idle(5'd7, 5'd8);

    // Randomized traffic over a small address space
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 49) == 0);
      s  = ($urandom_range(0, 4) == 0);
      av = ($urandom_range(0, 2) != 0);
      bv = ($urandom_range(0, 2) != 0);
      aa = 5'($urandom_range(0, 7));
      ba = 5'($urandom_range(0, 7));
      applyStimulus(r, s, av, aa, $urandom, bv, ba, $urandom,
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    repeat (3) idle(5'd0, 5'd0);

    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain actual=%0d expected=0 (pending writes)", expq.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports as follows:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
REQ-002 Requester A (ALU writeback) ports SHALL be:
- a_valid  in  1  write request present.
- a_ready  out  1  request accepted this cycle.
- a_addr  in  5  destination register.
- a_data  in  32  write data.
REQ-003 Requester B (load writeback) ports SHALL be:
- b_valid  in  1
- b_ready  out  1
- b_addr  in  5
- b_data  in  32
- All four have the same meaning as the A ports.
REQ-004 Control port: wb_stall  in  1  holds the arbiter; no grant while high.
REQ-005 Register-file write port:
- rf_write  out  1  write enable.
- rf_waddr  out  5  write address.
- rf_wdata  out  32  write data.
- This port drives the register file directly: reg_write, destination select resolved, write_data.
REQ-006 Forward port:
- fwd_rs  in  5
- fwd_rt  in  5
- fwd_hit_rs  out  1
- fwd_hit_rt  out  1
- fwd_data  out  32

Function
REQ-007 Handshake: a transfer on a requester occurs in a cycle when its valid and ready are both 1.
- ready is combinational from valid, wb_stall and arbiter state.
- ready never depends on its own requester's data.
REQ-008 At most one of a_ready/b_ready SHALL be 1 in any cycle.
- Both SHALL be 0 while wb_stall=1 or reset=1.
REQ-009 Arbitration SHALL be round-robin, with state LAST_A/LAST_B:
- Only A valid: grant A; only B valid: grant B.
- Both valid: grant the requester not granted last.
- State SHALL update only on a transfer.
REQ-010 Write latency SHALL be exactly one cycle.
- A transfer in cycle N drives rf_write=1 with the granted addr/data in cycle N+1 (registered outputs).
- rf_write SHALL be 0 in any cycle not following a transfer.
REQ-011 A transfer with addr==0 SHALL be accepted (ready=1) but produce rf_write=0 in N+1, so r0 stays 0.
- rf_waddr/rf_wdata SHALL still update.
REQ-012 Throughput: with both valid held high and wb_stall=0, grants SHALL alternate A,B,A,B… at one per cycle with no bubbles.
REQ-013 wb_stall asserted mid-stream:
- No new grants while it is high.
- An already-registered write in the output stage SHALL still complete in its cycle.
- Arbitration state SHALL be preserved across the stall.
REQ-014 Starvation counters:
- a_wait_cnt and b_wait_cnt (4 bits each, internal) increment each cycle their requester is valid and not granted, and clear on grant.
- They saturate at 15.
- A counter at 15 SHALL force grant to its requester, overriding round-robin.
- If both are at 15, A wins.

Reset
REQ-015 When reset=1 at a rising edge:
- rf_write=0, rf_waddr=0, rf_wdata=0.
- Round-robin state=LAST_B, so A has priority first.
- Both wait counters=0.
REQ-016 Reset mid-operation SHALL discard any registered, unwritten output write, leaving rf_write=0 the following cycle.
- Requesters SHALL see ready=0 during reset.

Configuration
REQ-017 Macro RF_WB_FWD_EN controls forwarding from the output stage.
- Defined: fwd_hit_rs=1 when rf_write=1 and rf_waddr==fwd_rs; fwd_hit_rt likewise against fwd_rt.
- Defined: fwd_data=rf_wdata; the hit outputs are combinational and never hit for address 0.
- Undefined: fwd_hit_rs=fwd_hit_rt=0 and fwd_data=0 constantly; ports remain present.

Structure
REQ-018 Shared package regfile_pkg SHALL hold:
- REG_ADDR_W=5, REG_DATA_W=32, REG_ZERO=5'd0.
- The rr_state_t enum {LAST_A, LAST_B}.
- WAIT_MAX=4'd15.
REQ-019 One sub-module, wb_wait_counter (a saturating 4-bit counter with clear), SHALL be instantiated twice.
- Arbitration and the output register stay in the top module.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Single request: reset, then a_valid=1, a_addr=3, a_data=0x0000_00AA for 1 cycle -> a_ready=1 that cycle; next cycle rf_write=1, rf_waddr=3, rf_wdata=0xAA.
- Contention: both valid continuously for 4 cycles from reset (A addr 1, B addr 2) -> grant order A,B,A,B; rf_waddr sequence 1,2,1,2 starting one cycle later.
- Zero register: b_valid=1, b_addr=0, b_data=0xFFFF_FFFF -> b_ready=1; next cycle rf_write=0.
- Stall: both valid, wb_stall=1 for 3 cycles after the first grant to A -> no ready during the stall; after release, first grant goes to B.
- Reset mid-stream: transfer A addr 5 in cycle N, reset=1 in cycle N -> rf_write=0 in cycle N+1; all outputs zero.
- Forwarding (RF_WB_FWD_EN defined): output-stage write addr 7, data 0x1234, fwd_rs=7, fwd_rt=8 -> fwd_hit_rs=1, fwd_hit_rt=0, fwd_data=0x1234. With the macro undefined, both hits are 0.
